ricosoc_iomem_uart: RTL

- Memory-mapped UART peripheral on the SoC iomem bus, downstream of the CPU's external-memory port.
- Consumes iomem_valid/addr/wdata/wstrb and returns iomem_ready/iomem_rdata.
- Serialises bytes through a TX FIFO, receives bytes into a single-entry RX buffer, and drives a level interrupt wired to irq_5.

---
 rtl/ricosoc_iomem_uart.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ricosoc_iomem_uart.sv
// iomem-mapped UART: TX FIFO and shifter, single-entry RX buffer, level irq; iomem_ready pulses 1 cycle after a selected valid.
// Bus is never stalled: DATA writes to a full FIFO are dropped (tx_ovf), an unread RX byte is overwritten (rx_ovf).
module ricosoc_iomem_uart #(
    parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
    parameter int unsigned DEFAULT_DIV = 104,
    parameter int unsigned TX_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq,
    output logic        ser_tx,
    input  logic        ser_rx
);
    localparam int AW = $clog2(TX_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_st_e;

    logic [31:0] div_q, div_d, rdata_q, rdata_d;
    logic [1:0]  irq_en_q, irq_en_d, rx_sync_q, rx_sync_d;
    logic        ready_q, ready_d, irq_q, irq_d, ser_tx_q, ser_tx_d, rx_last_q, rx_last_d;
    logic        rx_valid_q, rx_valid_d, rx_ovf_q, rx_ovf_d, frame_err_q, frame_err_d, tx_ovf_q, tx_ovf_d;
    logic [7:0]  fifo_q [TX_DEPTH];
    logic [7:0]  fifo_d [TX_DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    uart_st_e    tx_st_q, tx_st_d, rx_st_q, rx_st_d;
    logic [31:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_byte_q, rx_byte_d;

    logic        sel, acc, is_wr, tx_empty, tx_full, tx_idle, tx_load, rd_clr, rx_in;
    logic [31:0] div_eff, status;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^iomem_addr[1:0];
    assign sel      = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]);
    assign acc      = sel && !ready_q;
    assign is_wr    = |iomem_wstrb;
    assign tx_empty = (wptr_q == rptr_q);
    assign tx_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign tx_idle  = tx_empty && (tx_st_q == ST_IDLE);
    assign div_eff  = (div_q < 32'd2) ? 32'd2 : div_q;
    assign rx_in    = rx_sync_q[1];
    assign status   = {26'h0, tx_ovf_q, frame_err_q, rx_ovf_q, rx_valid_q, tx_idle, tx_full};

    always_comb begin
        div_d = div_q;           irq_en_d = irq_en_q;       ready_d = acc;          rdata_d = '0;
        rx_valid_d = rx_valid_q; rx_ovf_d = rx_ovf_q;       frame_err_d = frame_err_q;
        tx_ovf_d = tx_ovf_q;     fifo_d = fifo_q;           wptr_d = wptr_q;        rptr_d = rptr_q;
        tx_st_d = tx_st_q;       tx_cnt_d = tx_cnt_q;       tx_bit_d = tx_bit_q;    tx_sh_d = tx_sh_q;
        ser_tx_d = ser_tx_q;     rx_st_d = rx_st_q;         rx_cnt_d = rx_cnt_q;    rx_bit_d = rx_bit_q;
        rx_sh_d = rx_sh_q;       rx_byte_d = rx_byte_q;     rx_sync_d = {rx_sync_q[0], ser_rx};
        rx_last_d = rx_in;       tx_load = 1'b0;            rd_clr = 1'b0;

        if (acc) begin
            case (iomem_addr[3:2])
                2'd0: begin
                    rdata_d = div_q;
                    for (int b = 0; b < 4; b++)
                        if (iomem_wstrb[b]) div_d[8*b +: 8] = iomem_wdata[8*b +: 8];
                end
                2'd1: begin
                    if (is_wr) begin
                        if (iomem_wstrb[0]) begin
                            if (tx_full) tx_ovf_d = 1'b1;
                            else begin
                                fifo_d[wptr_q[AW-1:0]] = iomem_wdata[7:0];
                                wptr_d = wptr_q + PTR_ONE;
                            end
                        end
                    end else if (rx_valid_q) begin
                        rdata_d    = {24'h0, rx_byte_q};
                        rd_clr     = 1'b1;
                        rx_valid_d = 1'b0;
                    end else begin
                        rdata_d = 32'hFFFF_FFFF;
                    end
                end
                2'd2: begin
                    rdata_d = status;
                    if (is_wr && iomem_wstrb[0]) begin
                        if (iomem_wdata[3]) rx_ovf_d    = 1'b0;
                        if (iomem_wdata[4]) frame_err_d = 1'b0;
                        if (iomem_wdata[5]) tx_ovf_d    = 1'b0;
                    end
                end
                default: begin
                    rdata_d = {30'h0, irq_en_q};
                    if (is_wr && iomem_wstrb[0]) irq_en_d = iomem_wdata[1:0];
                end
            endcase
        end

        tx_cnt_d = tx_cnt_q - 32'd1;
        case (tx_st_q)
            ST_IDLE:  tx_load = !tx_empty;
            ST_START: if (tx_cnt_q == 32'd0) begin
                tx_st_d = ST_DATA; ser_tx_d = tx_sh_q[0]; tx_bit_d = 3'd0; tx_cnt_d = div_eff - 32'd1;
            end
            ST_DATA: if (tx_cnt_q == 32'd0) begin
                tx_cnt_d = div_eff - 32'd1;
                if (tx_bit_q == 3'd7) begin
                    tx_st_d = ST_STOP; ser_tx_d = 1'b1;
                end else begin
                    tx_bit_d = tx_bit_q + 3'd1; tx_sh_d = tx_sh_q >> 1; ser_tx_d = tx_sh_q[1];
                end
            end
            default: if (tx_cnt_q == 32'd0) begin
                tx_st_d = ST_IDLE;
                tx_load = !tx_empty;
            end
        endcase
        // Chaining straight from STOP into START keeps back-to-back frames gapless.
        if (tx_load) begin
            tx_sh_d  = fifo_q[rptr_q[AW-1:0]];
            rptr_d   = rptr_q + PTR_ONE;
            tx_st_d  = ST_START;
            ser_tx_d = 1'b0;
            tx_cnt_d = div_eff - 32'd1;
        end

        rx_cnt_d = rx_cnt_q - 32'd1;
        case (rx_st_q)
            ST_IDLE: if (rx_last_q && !rx_in) begin
                rx_st_d = ST_START; rx_cnt_d = (div_eff >> 1) - 32'd1;
            end
            ST_START: if (rx_cnt_q == 32'd0) begin
                rx_st_d = rx_in ? ST_IDLE : ST_DATA; rx_bit_d = 3'd0; rx_cnt_d = div_eff - 32'd1;
            end
            ST_DATA: if (rx_cnt_q == 32'd0) begin
                rx_sh_d  = {rx_in, rx_sh_q[7:1]};
                rx_cnt_d = div_eff - 32'd1;
                if (rx_bit_q == 3'd7) rx_st_d = ST_STOP;
                else rx_bit_d = rx_bit_q + 3'd1;
            end
            default: if (rx_cnt_q == 32'd0) begin
                rx_st_d = ST_IDLE;
                if (rx_in) begin
                    rx_byte_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                    if (rx_valid_q && !rd_clr) rx_ovf_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
        endcase

        irq_d = (irq_en_q[0] & rx_valid_q) | (irq_en_q[1] & tx_idle);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_q <= 32'(DEFAULT_DIV); irq_en_q <= '0; ready_q <= 1'b0; rdata_q <= '0; irq_q <= 1'b0;
            rx_valid_q <= 1'b0; rx_ovf_q <= 1'b0; frame_err_q <= 1'b0; tx_ovf_q <= 1'b0;
            wptr_q <= '0; rptr_q <= '0; tx_st_q <= ST_IDLE; tx_cnt_q <= '0; tx_bit_q <= '0;
            tx_sh_q <= '0; ser_tx_q <= 1'b1; rx_st_q <= ST_IDLE; rx_cnt_q <= '0; rx_bit_q <= '0;
            rx_sh_q <= '0; rx_byte_q <= '0; rx_sync_q <= 2'b11; rx_last_q <= 1'b1;
        end else begin
            div_q <= div_d; irq_en_q <= irq_en_d; ready_q <= ready_d; rdata_q <= rdata_d; irq_q <= irq_d;
            rx_valid_q <= rx_valid_d; rx_ovf_q <= rx_ovf_d; frame_err_q <= frame_err_d; tx_ovf_q <= tx_ovf_d;
            wptr_q <= wptr_d; rptr_q <= rptr_d; tx_st_q <= tx_st_d; tx_cnt_q <= tx_cnt_d; tx_bit_q <= tx_bit_d;
            tx_sh_q <= tx_sh_d; ser_tx_q <= ser_tx_d; rx_st_q <= rx_st_d; rx_cnt_q <= rx_cnt_d; rx_bit_q <= rx_bit_d;
            rx_sh_q <= rx_sh_d; rx_byte_q <= rx_byte_d; rx_sync_q <= rx_sync_d; rx_last_q <= rx_last_d;
        end
    end

    always_ff @(posedge clk) fifo_q <= fifo_d;

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign irq         = irq_q;
    assign ser_tx      = ser_tx_q;
endmodule
